// File: rtl/nes_mapper_pkg.sv
// Shared constants, encodings and helpers for the MMC1 bank-switching stage.
// Latency: none (declarations only).
// Backpressure: none.
package nes_mapper_pkg;

  // Register selected by latched CPU A14..A13 on the fifth serial write
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHR0 = 2'd1;
  localparam logic [1:0] REG_CHR1 = 2'd2;
  localparam logic [1:0] REG_PRG  = 2'd3;

  // PRG banking modes held in control[3:2]
  typedef enum logic [1:0] {
    PRG_MODE_32K_A     = 2'd0,
    PRG_MODE_32K_B     = 2'd1,
    PRG_MODE_FIX_FIRST = 2'd2,
    PRG_MODE_FIX_LAST  = 2'd3
  } prg_mode_e;

  // Nametable mirroring held in control[1:0]
  typedef enum logic [1:0] {
    MIRROR_ONE_LO = 2'd0,
    MIRROR_ONE_HI = 2'd1,
    MIRROR_VERT   = 2'd2,
    MIRROR_HORZ   = 2'd3
  } mirror_e;

  // Control value after reset and OR-mask applied by a data[7] write
  localparam logic [4:0] CTRL_RESET = 5'h0C;

  // Bank window sizes as address-bit counts (16 KB PRG, 4 KB CHR)
  localparam int PRG_BANK_BITS = 14;
  localparam int CHR_BANK_BITS = 12;

  // Serial count value at which the next bit completes a register
  localparam logic [2:0] SHIFT_LAST = 3'd4;

  // The four internal mapper registers
  typedef struct packed {
    logic [4:0] control;
    logic [4:0] chr0;
    logic [4:0] chr1;
    logic [4:0] prg;
  } mmc1_regs_t;

  // Unmasked 16 KB bank number for one CPU half ($8000 when a14=0)
  function automatic logic [3:0] prg_bank_sel(
    input prg_mode_e  mode,
    input logic [3:0] prg,
    input logic       a14,
    input logic [3:0] last_bank
  );
    logic [3:0] bank;
    bank = 4'd0;
    unique case (mode)
      PRG_MODE_32K_A,
      PRG_MODE_32K_B:     bank = {prg[3:1], a14};
      PRG_MODE_FIX_FIRST: bank = a14 ? prg : 4'd0;
      PRG_MODE_FIX_LAST:  bank = a14 ? last_bank : prg;
      default:            bank = 4'd0;
    endcase
    return bank;
  endfunction

endpackage

// File: rtl/nes_bus_sync.sv
// Synchronises M2/RW/ROMSEL into core clock and flags falling M2 edges.
// Latency: SYNC_STAGES clks to levels; write event on the clk the synced M2 falls.
// Backpressure: none; the CPU bus cannot be stalled.
module nes_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_m2,
  input  logic i_rw,
  input  logic i_rom_sel_n,
  output logic o_m2,
  output logic o_rw,
  output logic o_rom_sel_n,
  output logic o_wr_cond,
  output logic o_m2_fall,
  output logic o_write_event
);

  logic [SYNC_STAGES-1:0] r_m2_sync;
  logic [SYNC_STAGES-1:0] r_rw_sync;
  logic [SYNC_STAGES-1:0] r_sel_sync;
  logic                   r_m2_prev;
  logic                   r_cond_prev;

  // Synchroniser chains; reset to an idle bus (M2 low, read, ROM deselected)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m2_sync  <= '0;
      r_rw_sync  <= '1;
      r_sel_sync <= '1;
    end else begin
      r_m2_sync  <= {r_m2_sync[SYNC_STAGES-2:0], i_m2};
      r_rw_sync  <= {r_rw_sync[SYNC_STAGES-2:0], i_rw};
      r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], i_rom_sel_n};
    end
  end

  assign o_m2        = r_m2_sync[SYNC_STAGES-1];
  assign o_rw        = r_rw_sync[SYNC_STAGES-1];
  assign o_rom_sel_n = r_sel_sync[SYNC_STAGES-1];
  assign o_wr_cond   = o_m2 & ~o_rw & ~o_rom_sel_n;

  // One-clk history of synced M2 and of the ROM-write condition
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m2_prev   <= 1'b0;
      r_cond_prev <= 1'b0;
    end else begin
      r_m2_prev   <= o_m2;
      r_cond_prev <= o_wr_cond;
    end
  end

  // A write event is an M2 fall whose last high clk was a ROM write
  assign o_m2_fall     = r_m2_prev & ~o_m2;
  assign o_write_event = o_m2_fall & r_cond_prev;

endmodule

// File: rtl/mmc1_mapper.sv
// MMC1 mapper: serial register loads, PRG/CHR bank translation and mirroring.
// Latency: write applied SYNC_STAGES+1 clks after M2 falls; address maps 1 clk.
// Backpressure: none; every accepted CPU write is consumed as it arrives.
module mmc1_mapper
  import nes_mapper_pkg::*;
#(
  parameter logic [22:0] PRG_BASE    = 23'h000000,
  parameter int          PRG_BANKS   = 16,
  parameter int          CHR_BANKS   = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_m2,
  input  logic        cpu_rw,
  input  logic        cpu_rom_sel_n,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic [12:0] ppu_addr,
  output logic [22:0] prg_addr,
  output logic [16:0] chr_addr,
  output logic [1:0]  mirror,
  output logic        prg_ram_en,
  output logic        load_pulse
);

  localparam logic [3:0] PRG_MASK = 4'(PRG_BANKS - 1);
  localparam logic [4:0] CHR_MASK = 5'(CHR_BANKS - 1);

  logic w_m2, w_rw, w_rom_sel_n, w_wr_cond, w_m2_fall, w_write_event;

  nes_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk           (clk),
    .rst           (rst),
    .i_m2          (cpu_m2),
    .i_rw          (cpu_rw),
    .i_rom_sel_n   (cpu_rom_sel_n),
    .o_m2          (w_m2),
    .o_rw          (w_rw),
    .o_rom_sel_n   (w_rom_sel_n),
    .o_wr_cond     (w_wr_cond),
    .o_m2_fall     (w_m2_fall),
    .o_write_event (w_write_event)
  );

  // Only A14..A13 and data bits 7 and 0 matter to the serial port
  logic [1:0] r_lat_sel;
  logic       r_lat_d7;
  logic       r_lat_d0;

  // Track the CPU write while it is in progress; last value wins at M2 fall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat_sel <= 2'd0;
      r_lat_d7  <= 1'b0;
      r_lat_d0  <= 1'b0;
    end else if (w_wr_cond) begin
      r_lat_sel <= cpu_addr[14:13];
      r_lat_d7  <= cpu_data_in[7];
      r_lat_d0  <= cpu_data_in[0];
    end
  end

  mmc1_regs_t r_regs, w_regs_nxt;
  logic [4:0] r_shift, w_shift_nxt;
  logic [2:0] r_count, w_count_nxt;
  logic       r_prev_wr, w_prev_wr_nxt;
  logic       r_load_pulse, w_load_pulse_nxt;
  logic       w_accept;
  logic [4:0] w_value;

  // Serial-port next state: reset-bit, shift-in, or fifth-bit register load
  always_comb begin
    w_regs_nxt       = r_regs;
    w_shift_nxt      = r_shift;
    w_count_nxt      = r_count;
    w_prev_wr_nxt    = r_prev_wr;
    w_load_pulse_nxt = 1'b0;
    // RMW instructions write twice on back-to-back M2 cycles; only the first
    // loads, but a reset-bit write is honoured regardless
    w_accept = w_write_event & (~r_prev_wr | r_lat_d7);
    w_value  = {r_lat_d0, r_shift[4:1]};

    if (w_m2_fall) begin
      w_prev_wr_nxt = w_write_event;
    end

    if (w_accept) begin
      if (r_lat_d7) begin
        w_shift_nxt        = 5'd0;
        w_count_nxt        = 3'd0;
        w_regs_nxt.control = r_regs.control | CTRL_RESET;
      end else if (r_count == SHIFT_LAST) begin
        unique case (r_lat_sel)
          REG_CTRL: w_regs_nxt.control = w_value;
          REG_CHR0: w_regs_nxt.chr0    = w_value;
          REG_CHR1: w_regs_nxt.chr1    = w_value;
          REG_PRG:  w_regs_nxt.prg     = w_value;
          default:  w_regs_nxt         = r_regs;
        endcase
        w_shift_nxt      = 5'd0;
        w_count_nxt      = 3'd0;
        w_load_pulse_nxt = 1'b1;
      end else begin
        w_shift_nxt = w_value;
        w_count_nxt = r_count + 3'd1;
      end
    end
  end

  // Mapper state registers; reset wins over a same-clk write event
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs.control <= CTRL_RESET;
      r_regs.chr0    <= 5'd0;
      r_regs.chr1    <= 5'd0;
      r_regs.prg     <= 5'd0;
      r_shift        <= 5'd0;
      r_count        <= 3'd0;
      r_prev_wr      <= 1'b0;
      r_load_pulse   <= 1'b0;
    end else begin
      r_regs       <= w_regs_nxt;
      r_shift      <= w_shift_nxt;
      r_count      <= w_count_nxt;
      r_prev_wr    <= w_prev_wr_nxt;
      r_load_pulse <= w_load_pulse_nxt;
    end
  end

  prg_mode_e   w_prg_mode;
  logic [3:0]  w_prg_bank;
  logic [22:0] w_prg_addr;
  logic [4:0]  w_chr_bank;
  logic [16:0] w_chr_addr;

  // Combinational bank translation feeding the output registers
  always_comb begin
    w_prg_mode = prg_mode_e'(r_regs.control[3:2]);
    w_prg_bank = prg_bank_sel(w_prg_mode, r_regs.prg[3:0], cpu_addr[14],
                              PRG_MASK) & PRG_MASK;
    // Sum wraps naturally at 23 bits
    w_prg_addr = PRG_BASE + 23'({w_prg_bank, cpu_addr[PRG_BANK_BITS-1:0]});

    if (r_regs.control[4]) begin
      w_chr_bank = (ppu_addr[12] ? r_regs.chr1 : r_regs.chr0) & CHR_MASK;
      w_chr_addr = {w_chr_bank, ppu_addr[CHR_BANK_BITS-1:0]};
    end else begin
      // 8 KB mode ignores chr0[0]; A12 selects the 4 KB half directly
      w_chr_bank = r_regs.chr0 & CHR_MASK;
      w_chr_addr = {w_chr_bank[4:1], ppu_addr[12:0]};
    end
  end

  // Registered map outputs; pure datapath, valid one clk after inputs settle
  always_ff @(posedge clk) begin
    prg_addr   <= w_prg_addr;
    chr_addr   <= w_chr_addr;
    mirror     <= r_regs.control[1:0];
    prg_ram_en <= ~r_regs.prg[4];
  end

  assign load_pulse = r_load_pulse;

endmodule

// File: tb/tb_mmc1_mapper.sv
// Directed bench for mmc1_mapper: serial loads, RMW filter, reset, bank maps.
// Latency: outputs sampled on the falling clock edge, well after they settle.
// Backpressure: not applicable.
module tb_mmc1_mapper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_m2 = 1'b0;
  logic        cpu_rw = 1'b1;
  logic        cpu_rom_sel_n = 1'b1;
  logic [14:0] cpu_addr = 15'h0;
  logic [7:0]  cpu_data_in = 8'h0;
  logic [12:0] ppu_addr = 13'h0;

  logic [22:0] prg_addr, prg_addr8;
  logic [16:0] chr_addr, chr_addr8;
  logic [1:0]  mirror, mirror8;
  logic        prg_ram_en, prg_ram_en8;
  logic        load_pulse, load_pulse8;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;
  int p0;

  always #5 clk = ~clk;

  mmc1_mapper dut (
    .clk(clk), .rst(rst), .cpu_m2(cpu_m2), .cpu_rw(cpu_rw),
    .cpu_rom_sel_n(cpu_rom_sel_n), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .ppu_addr(ppu_addr),
    .prg_addr(prg_addr), .chr_addr(chr_addr), .mirror(mirror),
    .prg_ram_en(prg_ram_en), .load_pulse(load_pulse)
  );

  // Eight-bank variant with a base near the top of SDRAM to exercise wrap
  mmc1_mapper #(.PRG_BASE(23'h7F0000), .PRG_BANKS(8)) dut8 (
    .clk(clk), .rst(rst), .cpu_m2(cpu_m2), .cpu_rw(cpu_rw),
    .cpu_rom_sel_n(cpu_rom_sel_n), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .ppu_addr(ppu_addr),
    .prg_addr(prg_addr8), .chr_addr(chr_addr8), .mirror(mirror8),
    .prg_ram_en(prg_ram_en8), .load_pulse(load_pulse8)
  );

  always @(negedge clk) if (load_pulse === 1'b1) n_pulse++;

  task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One M2 cycle; wr=1 makes it a ROM write, otherwise a ROM read
  task automatic m2_cycle(input logic wr, input logic [14:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_data_in = d; cpu_rw = ~wr; cpu_rom_sel_n = 1'b0;
    cpu_m2 = 1'b1; tick(4);
    cpu_m2 = 1'b0; tick(2);
    cpu_rw = 1'b1; cpu_rom_sel_n = 1'b1; tick(4);
  endtask

  // Isolated write: followed by a read cycle so the next write is not filtered
  task automatic rom_write(input logic [14:0] a, input logic [7:0] d);
    m2_cycle(1'b1, a, d);
    m2_cycle(1'b0, a, d);
  endtask

  task automatic serial_load(input logic [14:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) rom_write(a, {7'b0, v[i]});
  endtask

  task automatic prg_at(input logic [14:0] a);
    cpu_addr = a; tick(2);
  endtask

  task automatic chr_at(input logic [12:0] a);
    ppu_addr = a; tick(2);
  endtask

  initial begin
    // 1: reset state and power-on mapping
    tick(3); rst = 1'b0; tick(1);
    prg_at(15'h4123);
    chk("t1_prg_c000", prg_addr, 23'h03C123);
    chk("t1_prg8_wrap", prg_addr8, 23'h00C123);
    prg_at(15'h0000);
    chk("t1_prg_8000", prg_addr, 23'h000000);
    chk("t1_mirror", 23'(mirror), 23'd0);
    chk("t1_ram_en", 23'(prg_ram_en), 23'd1);
    chk("t1_load_pulse", 23'(load_pulse), 23'd0);
    chr_at(13'h1234);
    chk("t1_chr", 23'(chr_addr), 23'h01234);

    // 2: prg=5 via five isolated writes to $E000
    p0 = n_pulse;
    serial_load(15'h6000, 5'b00101);
    chk("t2_one_pulse", 23'(n_pulse - p0), 23'd1);
    prg_at(15'h0010);
    chk("t2_prg_lo", prg_addr, 23'h014010);
    prg_at(15'h4000);
    chk("t2_prg_hi", prg_addr, 23'h03C000);
    chk("t2_ram_en", 23'(prg_ram_en), 23'd1);

    // 3: partial load cancelled by bit 7, then control=5'h12
    p0 = n_pulse;
    rom_write(15'h0000, 8'h01);
    rom_write(15'h0000, 8'h01);
    rom_write(15'h0000, 8'h80);
    chk("t3_no_pulse_reset", 23'(n_pulse - p0), 23'd0);
    chk("t3_mirror_kept", 23'(mirror), 23'd0);
    serial_load(15'h0000, 5'h12);
    chk("t3_ctrl_pulse", 23'(n_pulse - p0), 23'd1);
    chk("t3_mirror_vert", 23'(mirror), 23'd2);
    prg_at(15'h0010);
    chk("t3_prg32k_lo", prg_addr, 23'h010010);
    prg_at(15'h4010);
    chk("t3_prg32k_hi", prg_addr, 23'h014010);
    serial_load(15'h2000, 5'd3);
    serial_load(15'h4000, 5'd7);
    chr_at(13'h0010);
    chk("t3_chr0", 23'(chr_addr), 23'h03010);
    chr_at(13'h1010);
    chk("t3_chr1", 23'(chr_addr), 23'h07010);
    // Bit-7 write ORs 5'h0C into control: PRG mode 3, mirroring untouched
    p0 = n_pulse;
    rom_write(15'h0000, 8'h80);
    prg_at(15'h0010);
    chk("t3_or_mode3", prg_addr, 23'h014010);
    chk("t3_or_mirror", 23'(mirror), 23'd2);
    chk("t3_or_no_pulse", 23'(n_pulse - p0), 23'd0);

    // 4: RMW double write counts once; load completes on the 4th isolated write
    p0 = n_pulse;
    m2_cycle(1'b1, 15'h2000, 8'h01);
    m2_cycle(1'b1, 15'h2000, 8'h01);
    m2_cycle(1'b0, 15'h2000, 8'h00);
    rom_write(15'h2000, 8'h01);
    rom_write(15'h2000, 8'h01);
    rom_write(15'h2000, 8'h00);
    chk("t4_no_early_load", 23'(n_pulse - p0), 23'd0);
    rom_write(15'h2000, 8'h00);
    chk("t4_one_load", 23'(n_pulse - p0), 23'd1);
    chr_at(13'h0010);
    chk("t4_chr0_7", 23'(chr_addr), 23'h07010);

    // 5: reset mid-load discards partial shift
    rom_write(15'h2000, 8'h00);
    rom_write(15'h2000, 8'h00);
    rom_write(15'h2000, 8'h00);
    rst = 1'b1; tick(3); rst = 1'b0; tick(2);
    chk("t5_mirror_rst", 23'(mirror), 23'd0);
    chk("t5_chr_rst", 23'(chr_addr), 23'h00010);
    p0 = n_pulse;
    serial_load(15'h2000, 5'h1F);
    chk("t5_one_pulse", 23'(n_pulse - p0), 23'd1);
    chr_at(13'h0010);
    chk("t5_chr8k_lo", 23'(chr_addr), 23'h1E010);
    chr_at(13'h1010);
    chk("t5_chr8k_hi", 23'(chr_addr), 23'h1F010);

    // 6: bank masking with 8 banks and PRG RAM disable
    serial_load(15'h6000, 5'h0F);
    prg_at(15'h0123);
    chk("t6_prg16_lo", prg_addr, 23'h03C123);
    chk("t6_prg8_lo", prg_addr8, 23'h00C123);
    prg_at(15'h4000);
    chk("t6_prg8_hi", prg_addr8, 23'h00C000);
    chk("t6_ram_en_on", 23'(prg_ram_en8), 23'd1);
    serial_load(15'h6000, 5'h1F);
    chk("t6_ram_en_off", 23'(prg_ram_en), 23'd0);
    chk("t6_ram_en8_off", 23'(prg_ram_en8), 23'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
